// File: rtl/id_stage_q.sv
// Decode stage with an instruction queue in front of it and a valid-tagged
// pipeline register towards EX.
module id_stage_q #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int GPR_W   = 32,
  parameter int RF_SIZE = 16,
  parameter int DEPTH   = 4,
  parameter int CTRL_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic               ctrl_is_jump,
  input  logic               ctrl_sel_j_jr,
  input  logic               ctrl_imm_zext,
  input  logic               stall,
  input  logic               flush,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  input  logic [GPR_W-1:0]   data_rs,
  input  logic [GPR_W-1:0]   data_rt,
  output logic [PC_W-1:0]    jump_addr,
  output logic               is_jump,
  output logic               out_valid,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [GPR_W-1:0]   out_imm,
  output logic [PC_W-1:0]    out_next_pc,
  output logic [GPR_W-1:0]   out_data_rs,
  output logic [GPR_W-1:0]   out_data_rt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [4:0] RMAX = 5'(RF_SIZE - 1);

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [CW-1:0]      r_cnt;

  logic               r_valid;
  logic [CTRL_W-1:0]  r_ctrl;
  logic [4:0]         r_rd;
  logic [4:0]         r_rs;
  logic [4:0]         r_rt;
  logic [GPR_W-1:0]   r_imm;
  logic [PC_W-1:0]    r_npc;
  logic [GPR_W-1:0]   r_drs;
  logic [GPR_W-1:0]   r_drt;

  logic               w_empty;
  logic [INSTR_W-1:0] w_hi;
  logic [PC_W-1:0]    w_hpc;
  logic [4:0]         w_rs_f;
  logic [4:0]         w_rt_f;
  logic [4:0]         w_rd_f;
  logic [15:0]        w_imm;
  logic [25:0]        w_tgt;
  logic               w_head_ok;
  logic               w_jump;
  logic               w_push;
  logic               w_pop;
  logic [GPR_W-1:0]   w_imm_x;

  // Head fields read as zero while the queue is empty.
  assign w_empty = (r_cnt == '0);
  assign w_hi    = w_empty ? '0 : r_instr[r_rp];
  assign w_hpc   = w_empty ? '0 : r_pc[r_rp];

  assign w_rs_f = w_hi[25:21];
  assign w_rt_f = w_hi[20:16];
  assign w_rd_f = w_hi[15:11];
  assign w_imm  = w_hi[15:0];
  assign w_tgt  = w_hi[25:0];

  assign opcode = w_hi[INSTR_W-1 -: 6];
  assign funct  = w_hi[5:0];

  assign rs = (int'(w_rs_f) < RF_SIZE) ? w_rs_f : RMAX;
  assign rt = (int'(w_rt_f) < RF_SIZE) ? w_rt_f : RMAX;

  assign jump_addr = ctrl_sel_j_jr ? PC_W'(w_tgt)
                                   : PC_W'(data_rs);

  assign in_ready  = (r_cnt < FULL);
  assign w_head_ok = !w_empty && !stall && !flush;
  assign w_jump    = ctrl_is_jump && w_head_ok;
  assign is_jump   = w_jump;
  assign w_pop     = w_head_ok;
  assign w_push    = in_valid && in_ready
                   && !flush && !w_jump;

  assign w_imm_x = ctrl_imm_zext
                 ? GPR_W'(w_imm)
                 : {{(GPR_W-16){w_imm[15]}}, w_imm};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wp] <= in_instr;
      r_pc[r_wp]    <= in_pc;
    end
  end

  // A flush or a taken decode jump discards everything still queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else if (flush || w_jump) begin
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_imm   <= '0;
      r_npc   <= '0;
      r_drs   <= '0;
      r_drt   <= '0;
    end else if (!w_head_ok) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid <= 1'b1;
      r_ctrl  <= ctrl_in;
      r_rd    <= w_rd_f;
      r_rs    <= w_rs_f;
      r_rt    <= w_rt_f;
      r_imm   <= w_imm_x;
      r_npc   <= w_hpc + PC_W'(1);
      r_drs   <= data_rs;
      r_drt   <= data_rt;
    end
  end

  assign out_valid   = r_valid;
  assign out_ctrl    = r_ctrl;
  assign out_rd      = r_rd;
  assign out_rs      = r_rs;
  assign out_rt      = r_rt;
  assign out_imm     = r_imm;
  assign out_next_pc = r_npc;
  assign out_data_rs = r_drs;
  assign out_data_rt = r_drt;

endmodule

// File: doc/id_stage_q.md
Name: id_stage_q

Overview:
- Parametrised decode stage sitting between IF and EX.
- A DEPTH-entry instruction queue decouples fetch from decode.
- The head entry is decoded: register addresses go to the register file, opcode/funct go to the external control_unit, and the control bundle comes back in.
- The pipeline register to EX carries a valid bit, with stall-bubble, flush and decode-jump squash behaviour.

Parameters:
- INSTR_W, 32, instruction width (opcode [INSTR_W-1:INSTR_W-6], rs [25:21], rt [20:16], rd [15:11], imm [15:0], target [25:0])
- PC_W, 32, PC width
- GPR_W, 32, register data width
- RF_SIZE, 16, number of architectural registers
- DEPTH, 4, queue entries (power of 2, >=2)
- CTRL_W, 16, width of control bundle from control_unit

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IF presents instruction
- in_instr  in  INSTR_W  fetched instruction
- in_pc  in  PC_W  PC of in_instr
- in_ready  out  1  queue can accept
- opcode  out  6  head opcode to control_unit
- funct  out  6  head funct to control_unit
- ctrl_in  in  CTRL_W  control bundle from control_unit
- ctrl_is_jump  in  1  head is unconditional jump
- ctrl_sel_j_jr  in  1  1=absolute target, 0=register (jr)
- ctrl_imm_zext  in  1  1=zero-extend imm
- stall  in  1  hazard unit stall
- flush  in  1  taken branch resolved downstream
- rs, rt  out  5  register-file read addresses
- data_rs, data_rt  in  GPR_W  register-file read data
- jump_addr  out  PC_W  jump target to IF
- is_jump  out  1  jump taken this cycle
- out_valid  out  1  EX register holds a real instruction
- out_ctrl  out  CTRL_W  registered control bundle
- out_rd, out_rs, out_rt  out  5  registered fields (raw, unclamped)
- out_imm  out  GPR_W  extended immediate
- out_next_pc  out  PC_W  pc+1
- out_data_rs, out_data_rt  out  GPR_W  registered operands

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - Queue empty, count=0, pointers=0.
  - All out_* = 0, out_valid=0.
  - Takes effect mid-operation regardless of other inputs.
- Queue and handshake:
  - in_ready = (count<DEPTH). It does not depend on pop, so there is no push when full, even if a pop occurs that cycle.
  - push = in_valid & in_ready & !flush & !is_jump.
  - Pointers wrap modulo DEPTH.
- Head decode (combinational from head entry; fields are 0 when queue is empty):
  - rs/rt = field if < RF_SIZE, else RF_SIZE-1.
  - jump_addr = ctrl_sel_j_jr ? zero-extended target[25:0] : data_rs.
  - head_ok = (count>0) & !stall & !flush.
  - is_jump = ctrl_is_jump & head_ok.
- Pop: pop = head_ok (1 per cycle). On is_jump, all entries behind the head are discarded: count->0 next cycle.
- EX register update, each cycle, priority in order:
  - flush: out_valid=0, out_ctrl=0, queue emptied, no push.
  - stall or empty: bubble (out_valid=0, out_ctrl=0, other fields don't-care/hold); head retained.
  - else: out_valid=1, out_ctrl=ctrl_in, fields from head, out_next_pc = head pc+1 mod 2^PC_W.
    - out_imm = ctrl_imm_zext ? {0,imm} : {sign,imm}.
    - out_data_rs/rt = data_rs/rt.
- Latency:
  - Instruction pushed at edge N is decoded at cycle N+1 earliest.
  - It appears on out_* after edge N+1.
  - With continuous flow, throughput is 1/cycle.
- Count arithmetic:
  - push & pop: unchanged.
  - Never exceeds DEPTH, never underflows.

Test Plan:
- Reset with queue full → next cycle count=0, in_ready=1, out_valid=0, all out_*=0.
- Push 4 ALU instrs at pc 0..3, no stall → out_valid=1 on 4 consecutive cycles, out_next_pc=1,2,3,4, out_imm sign-extended (imm 0xFFFF→0xFFFFFFFF; with zext→0x0000FFFF).
- Hold stall 3 cycles with 2 queued → out_valid=0 three cycles, head unchanged, rs/rt stable; release → both issue back-to-back.
- Queue full (4) with stall, in_valid=1 → in_ready=0, instr not accepted; drop stall → in_ready=1 one cycle later.
- Head j 0x100 with 3 entries behind → is_jump=1, jump_addr=0x100, EX gets the jump, count=0 next cycle; same-cycle in_valid discarded. jr with data_rs=0x2A → jump_addr=0x2A.
- flush with stall=1 and 3 queued → queue empty, out_valid=0; rs field 20 with RF_SIZE=16 → rs=15, out_rs=20.
